aes_key_schedule: RTL and testbench

Iterative, parametrised AES key-schedule engine supporting 128-, 192- and 256-bit cipher keys. It expands the cipher key into all round keys, generating one 32-bit word per clock through a single shared 4-byte aes_sbox bank. Words are held in an internal word store, and any round key can be read back by index. Decryption reads rounds Nr..0 in reverse order; encryption reads them forward.

---
 rtl/aes_key_schedule.sv | 189 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock through a
// single shared 4-byte S-box bank, with an indexed, registered round-key read port.

module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sboxFn(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign o_out = sboxFn(i_in);

endmodule

module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [KEY_BITS-1:0] i_key,
  output logic                o_busy,
  output logic                o_key_valid,
  input  logic                i_rd_en,
  input  logic [3:0]          i_rd_round,
  output logic [127:0]        o_rd_key,
  output logic                o_rd_valid,
  output logic                o_rd_err
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = 6;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_badKeyBits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t        r_state;
  logic [31:0]   r_w [NW];
  logic [IW-1:0] r_i;
  logic [2:0]    r_kmod;
  logic [7:0]    r_rc;
  logic          r_busy;
  logic          r_keyValid;
  logic [127:0]  r_rdKey;
  logic          r_rdValid;
  logic          r_rdErr;

  logic          w_accept;
  logic          w_expWe;
  logic [31:0]   w_prev;
  logic [31:0]   w_old;
  logic [31:0]   w_subIn;
  logic [31:0]   w_sub;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic          w_rdLegal;
  logic [3:0]    w_rdIdx;

  assign w_accept = i_start && (r_state != EXPAND);
  // The final EXPAND cycle (r_i == NW) writes nothing; it only hands over to READY.
  assign w_expWe  = (r_state == EXPAND) && (r_i != IW'(NW));
  assign w_prev   = r_w[r_i - 6'd1];
  assign w_old    = r_w[r_i - IW'(NK)];
  assign w_subIn  = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_in  (w_subIn[8*b +: 8]),
      .o_out (w_sub[8*b +: 8])
    );
  end

  always_comb begin
    w_temp = w_prev;
    if (r_kmod == 3'd0) begin
      w_temp = w_sub ^ {r_rc, 24'h000000};
    end else if (NK == 8 && r_kmod == 3'd4) begin
      w_temp = w_sub;
    end
  end

  assign w_new = w_old ^ w_temp;

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= i_key[KEY_BITS-1-32*k -: 32];
      end
    end else if (w_expWe) begin
      r_w[r_i] <= w_new;
    end
  end

  // r_kmod tracks i mod NK and r_rc the Rcon byte, so no divider is needed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_kmod     <= '0;
      r_rc       <= 8'h01;
      r_busy     <= 1'b0;
      r_keyValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, READY: begin
          if (i_start) begin
            r_state    <= EXPAND;
            r_i        <= IW'(NK);
            r_kmod     <= 3'd0;
            r_rc       <= 8'h01;
            r_busy     <= 1'b1;
            r_keyValid <= 1'b0;
          end
        end
        EXPAND: begin
          if (r_i == IW'(NW)) begin
            r_state    <= READY;
            r_busy     <= 1'b0;
            r_keyValid <= 1'b1;
          end else begin
            r_i    <= r_i + 6'd1;
            r_kmod <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
            if (r_kmod == 3'd0) r_rc <= {r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1b : 8'h00);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rdLegal = r_keyValid && (i_rd_round <= 4'(NR));
  assign w_rdIdx   = w_rdLegal ? i_rd_round : 4'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdKey   <= '0;
      r_rdValid <= 1'b0;
      r_rdErr   <= 1'b0;
    end else begin
      r_rdValid <= i_rd_en;
      if (i_rd_en) begin
        if (w_rdLegal) begin
          r_rdKey <= {r_w[{w_rdIdx, 2'd0}], r_w[{w_rdIdx, 2'd1}],
                      r_w[{w_rdIdx, 2'd2}], r_w[{w_rdIdx, 2'd3}]};
          r_rdErr <= 1'b0;
        end else begin
          r_rdKey <= '0;
          r_rdErr <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_key_valid = r_keyValid;
  assign o_rd_key    = r_rdKey;
  assign o_rd_valid  = r_rdValid;
  assign o_rd_err    = r_rdErr;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: one instance per key size, known-answer vectors plus
// random keys and reads checked against a table-driven key-expansion model.

module tb_aes_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        start;
  logic [2:0]        rdEn;
  logic [2:0]        busy;
  logic [2:0]        keyValid;
  logic [2:0]        rdValid;
  logic [2:0]        rdErr;
  logic [2:0][3:0]   rdRound;
  logic [2:0][127:0] rdKey;
  logic [127:0]      key128;
  logic [191:0]      key192;
  logic [255:0]      key256;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sboxRef [256];
  logic [31:0] modelW [3][60];
  logic [7:0]  rconTab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_schedule #(.KEY_BITS(128)) u_dut128 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_key(key128),
    .o_busy(busy[0]), .o_key_valid(keyValid[0]), .i_rd_en(rdEn[0]),
    .i_rd_round(rdRound[0]), .o_rd_key(rdKey[0]), .o_rd_valid(rdValid[0]),
    .o_rd_err(rdErr[0])
  );

  aes_key_schedule #(.KEY_BITS(192)) u_dut192 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_key(key192),
    .o_busy(busy[1]), .o_key_valid(keyValid[1]), .i_rd_en(rdEn[1]),
    .i_rd_round(rdRound[1]), .o_rd_key(rdKey[1]), .o_rd_valid(rdValid[1]),
    .o_rd_err(rdErr[1])
  );

  aes_key_schedule #(.KEY_BITS(256)) u_dut256 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_key(key256),
    .o_busy(busy[2]), .o_key_valid(keyValid[2]), .i_rd_en(rdEn[2]),
    .i_rd_round(rdRound[2]), .o_rd_key(rdKey[2]), .o_rd_valid(rdValid[2]),
    .o_rd_err(rdErr[2])
  );

  function automatic int nkOf(input int cfg);
    return 4 + 2 * cfg;
  endfunction

  function automatic int nrOf(input int cfg);
    return nkOf(cfg) + 6;
  endfunction

  function automatic int latencyOf(input int cfg);
    return 4 * (nrOf(cfg) + 1) - nkOf(cfg) + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // S-box table built by walking the multiplicative group with generator 3.
  task automatic buildSbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxRef[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxRef[0] = 8'h63;
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
  endfunction

  task automatic modelExpand(input int cfg, input logic [255:0] k);
    int nk;
    logic [31:0] t;
    nk = nkOf(cfg);
    for (int j = 0; j < nk; j++) modelW[cfg][j] = k[32*(nk-1-j) +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = modelW[cfg][i-1];
      if (i % nk == 0) t = subWord({t[23:0], t[31:24]}) ^ {rconTab[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subWord(t);
      modelW[cfg][i] = modelW[cfg][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] roundRef(input int cfg, input int r);
    return {modelW[cfg][4*r], modelW[cfg][4*r+1], modelW[cfg][4*r+2], modelW[cfg][4*r+3]};
  endfunction

  function automatic logic [255:0] randomKey();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  task automatic setKey(input int cfg, input logic [255:0] k);
    case (cfg)
      0:       key128 = k[127:0];
      1:       key192 = k[191:0];
      default: key256 = k;
    endcase
  endtask

  task automatic applyStimulus(input int cfg, input logic [255:0] k);
    setKey(cfg, k);
    start[cfg] = 1'b1;
    @(posedge clk);
    #1;
    start[cfg] = 1'b0;
  endtask

  // Counts edges after the accepting edge until key_valid; optionally pulses a
  // stray start at edge startAt, or asserts reset at edge rstAt and gives up.
  task automatic waitValid(input int cfg, input int expected, input int startAt,
                           input int rstAt, input string tag);
    int  n;
    bit  done;
    checkOutput({tag, "_busyHigh"}, 128'(busy[cfg]), 128'd1);
    checkOutput({tag, "_kvLow"}, 128'(keyValid[cfg]), 128'd0);
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      if (n + 1 == startAt) begin
        setKey(cfg, randomKey());
        start[cfg] = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      start[cfg] = 1'b0;
      if (n == rstAt) begin
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rstBusy"}, 128'(busy[cfg]), 128'd0);
        checkOutput({tag, "_rstKv"}, 128'(keyValid[cfg]), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (keyValid[cfg]) done = 1'b1;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(expected));
    checkOutput({tag, "_busyLow"}, 128'(busy[cfg]), 128'd0);
  endtask

  task automatic readRound(input int cfg, input int r, input logic [127:0] expKey,
                           input logic expErr, input string tag);
    rdRound[cfg] = 4'(r);
    rdEn[cfg]    = 1'b1;
    @(posedge clk);
    #1;
    rdEn[cfg] = 1'b0;
    checkOutput({tag, "_valid"}, 128'(rdValid[cfg]), 128'd1);
    checkOutput({tag, "_err"}, 128'(rdErr[cfg]), 128'(expErr));
    checkOutput({tag, "_key"}, rdKey[cfg], expKey);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] fips128;
    logic [191:0] fips192;
    logic [255:0] fips256;
    logic [255:0] newKey;
    logic [127:0] old10;
    int           r;

    fips128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    fips256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    buildSbox();
    rst     = 1'b1;
    start   = '0;
    rdEn    = '0;
    rdRound = '0;
    key128  = '0;
    key192  = '0;
    key256  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("reset%0d_busy", c), 128'(busy[c]), 128'd0);
      checkOutput($sformatf("reset%0d_kv", c), 128'(keyValid[c]), 128'd0);
      checkOutput($sformatf("reset%0d_rdValid", c), 128'(rdValid[c]), 128'd0);
      checkOutput($sformatf("reset%0d_rdErr", c), 128'(rdErr[c]), 128'd0);
      checkOutput($sformatf("reset%0d_rdKey", c), rdKey[c], 128'd0);
    end
    rst = 1'b0;

    readRound(0, 0, 128'd0, 1'b1, "preExpandRead");

    modelExpand(0, 256'(fips128));
    applyStimulus(0, 256'(fips128));
    waitValid(0, 41, 0, 0, "fips128");
    readRound(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "fips128_r1");
    readRound(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "fips128_r10");
    readRound(0, 0, fips128, 1'b0, "fips128_r0");
    for (int k = 10; k >= 0; k--) readRound(0, k, roundRef(0, k), 1'b0, $sformatf("burst_r%0d", k));
    readRound(0, 11, 128'd0, 1'b1, "fips128_r11");

    readRound(0, 5, roundRef(0, 5), 1'b0, "holdSetup");
    @(posedge clk);
    #1;
    checkOutput("hold_valid", 128'(rdValid[0]), 128'd0);
    checkOutput("hold_key", rdKey[0], roundRef(0, 5));

    applyStimulus(0, 256'(fips128));
    waitValid(0, 41, 10, 0, "ignoredStart");
    readRound(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "ignoredStart_r10");

    // Restart from READY with a read on the same edge: that read still sees the old key.
    newKey = randomKey();
    old10  = roundRef(0, 10);
    setKey(0, newKey);
    start[0]   = 1'b1;
    rdEn[0]    = 1'b1;
    rdRound[0] = 4'd10;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    rdEn[0]  = 1'b0;
    checkOutput("restartRead_valid", 128'(rdValid[0]), 128'd1);
    checkOutput("restartRead_err", 128'(rdErr[0]), 128'd0);
    checkOutput("restartRead_key", rdKey[0], old10);
    modelExpand(0, newKey);
    waitValid(0, 41, 0, 0, "restart");
    readRound(0, 10, roundRef(0, 10), 1'b0, "restart_r10");

    modelExpand(0, 256'(fips128));
    applyStimulus(0, 256'(fips128));
    waitValid(0, 41, 0, 20, "rstMid");
    readRound(0, 1, 128'd0, 1'b1, "rstMid_read");
    applyStimulus(0, 256'(fips128));
    waitValid(0, 41, 0, 0, "afterRst");
    readRound(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "afterRst_r10");

    modelExpand(1, 256'(fips192));
    applyStimulus(1, 256'(fips192));
    waitValid(1, 47, 0, 0, "fips192");
    readRound(1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b0, "fips192_r12");
    readRound(1, 0, 128'(fips192 >> 64), 1'b0, "fips192_r0");
    readRound(1, 13, 128'd0, 1'b1, "fips192_r13");

    modelExpand(2, fips256);
    applyStimulus(2, fips256);
    waitValid(2, 53, 0, 0, "fips256");
    readRound(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0, "fips256_r14");
    readRound(2, 1, fips256[127:0], 1'b0, "fips256_r1");
    readRound(2, 15, 128'd0, 1'b1, "fips256_r15");

    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < 3; t++) begin
        newKey = randomKey();
        modelExpand(c, newKey);
        applyStimulus(c, newKey);
        waitValid(c, latencyOf(c), 0, 0, $sformatf("rand%0d_%0d", c, t));
        for (int q = 0; q < 12; q++) begin
          r = int'($urandom_range(0, 15));
          if (r <= nrOf(c)) readRound(c, r, roundRef(c, r), 1'b0, $sformatf("rand%0d_%0d_r%0d", c, t, r));
          else readRound(c, r, 128'd0, 1'b1, $sformatf("rand%0d_%0d_bad%0d", c, t, r));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d_%0d_idle", c, t), 128'(rdValid[c]), 128'd0);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
